pry2oht_scan: RTL and testbench

//  Iterative priority scanner: accepts a WIDTH-bit request vector on a valid/ready input and

---
 rtl/pry2oht_scan.sv | 80 ++++++++
 tb/tb_pry2oht_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pry2oht_scan.sv
// Iterative priority scanner: takes a request vector, then emits each set bit as one
// beat per cycle (one-hot plus binary index), highest priority first, under valid/ready.
module pry2oht_scan #(
  parameter int WIDTH     = 9,
  parameter     DIRECTION = "LSB",
  parameter int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [WIDTH-1:0]     i_pry,
  output logic                 i_rdy,
  output logic                 o_vld,
  output logic [WIDTH-1:0]     o_oht,
  output logic [WIDTH_LOG-1:0] o_bin,
  output logic                 o_lst,
  input  logic                 o_rdy
);

  localparam bit MSB_FIRST = (DIRECTION == "MSB");

  // Bits still to be emitted; all-zero means idle.
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     pick_oht;
  logic [WIDTH_LOG-1:0] pick_bin;
  logic                 found;
  logic                 in_xfer;
  logic                 out_xfer;

  // Scan position k maps to bit index k (LSB first) or WIDTH-1-k (MSB first).
  function automatic int scan_pos(input int k);
    return MSB_FIRST ? (WIDTH - 1 - k) : k;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_oht = '0;
    pick_bin = '0;
    found    = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && rem_q[scan_pos(k)]) begin
        found                = 1'b1;
        pick_oht[scan_pos(k)] = 1'b1;
        pick_bin             = WIDTH_LOG'(scan_pos(k));
      end
    end
  end

  // Outputs depend on rem_q only, so there is no combinational i_* -> o_* path.
  assign o_vld = |rem_q;
  assign o_oht = pick_oht;
  assign o_bin = pick_bin;
  assign o_lst = o_vld && ((rem_q & ~pick_oht) == '0);

  // Accept a new vector while idle, or in the cycle the last beat leaves (no bubble).
  assign i_rdy    = !o_vld || (o_lst && o_rdy);
  assign in_xfer  = i_vld && i_rdy;
  assign out_xfer = o_vld && o_rdy;

  always_comb begin
    rem_d = rem_q;
    if (in_xfer) begin
      rem_d = i_pry;
    end else if (out_xfer) begin
      rem_d = rem_q & ~pick_oht;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so
  // anything presented on the inputs during a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: tb/tb_pry2oht_scan.sv
// Directed bench for pry2oht_scan: one LSB-first and one MSB-first instance, WIDTH=9,
// with hand-computed beat sequences checked every cycle.
module tb_pry2oht_scan;

  localparam int W  = 9;
  localparam int WL = 4;

  logic          clk;
  logic          rst;
  logic          l_ivld, l_irdy, l_ovld, l_olst, l_ordy;
  logic [W-1:0]  l_pry, l_oht;
  logic [WL-1:0] l_bin;
  logic          m_ivld, m_irdy, m_ovld, m_olst, m_ordy;
  logic [W-1:0]  m_pry, m_oht;
  logic [WL-1:0] m_bin;

  int n_checks = 0;
  int n_errors = 0;

  pry2oht_scan #(.WIDTH(W), .DIRECTION("LSB")) dut_lsb (
    .clk(clk), .rst(rst), .i_vld(l_ivld), .i_pry(l_pry), .i_rdy(l_irdy),
    .o_vld(l_ovld), .o_oht(l_oht), .o_bin(l_bin), .o_lst(l_olst), .o_rdy(l_ordy)
  );

  pry2oht_scan #(.WIDTH(W), .DIRECTION("MSB")) dut_msb (
    .clk(clk), .rst(rst), .i_vld(m_ivld), .i_pry(m_pry), .i_rdy(m_irdy),
    .o_vld(m_ovld), .o_oht(m_oht), .o_bin(m_bin), .o_lst(m_olst), .o_rdy(m_ordy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs of the selected instance (m=1 -> MSB instance).
  task automatic beat(input bit m, input string tag, input bit vld, input int bin,
                      input bit lst, input bit irdy);
    logic [31:0] e_oht;
    e_oht = vld ? (32'd1 << bin) : 32'd0;
    if (m) begin
      chk({tag, ".o_vld"}, {31'd0, m_ovld}, {31'd0, vld});
      chk({tag, ".o_oht"}, {23'd0, m_oht}, e_oht);
      chk({tag, ".o_bin"}, {28'd0, m_bin}, vld ? bin : 0);
      chk({tag, ".o_lst"}, {31'd0, m_olst}, {31'd0, lst});
      chk({tag, ".i_rdy"}, {31'd0, m_irdy}, {31'd0, irdy});
    end else begin
      chk({tag, ".o_vld"}, {31'd0, l_ovld}, {31'd0, vld});
      chk({tag, ".o_oht"}, {23'd0, l_oht}, e_oht);
      chk({tag, ".o_bin"}, {28'd0, l_bin}, vld ? bin : 0);
      chk({tag, ".o_lst"}, {31'd0, l_olst}, {31'd0, lst});
      chk({tag, ".i_rdy"}, {31'd0, l_irdy}, {31'd0, irdy});
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
  task automatic settle();
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    l_ivld = 1'b1; l_pry = 9'h1FF; l_ordy = 1'b1;
    m_ivld = 1'b1; m_pry = 9'h1FF; m_ordy = 1'b1;

    // Test 1: reset held two cycles with a full vector offered; nothing is loaded.
    next_cycle(); settle();
    beat(0, "rst_c1_lsb", 0, 0, 0, 1);
    beat(1, "rst_c1_msb", 0, 0, 0, 1);
    next_cycle(); settle();
    beat(0, "rst_c2_lsb", 0, 0, 0, 1);
    beat(1, "rst_c2_msb", 0, 0, 0, 1);
    rst = 1'b0; l_ivld = 1'b0; m_ivld = 1'b0;
    next_cycle(); settle();
    beat(0, "rst_after_lsb", 0, 0, 0, 1);
    beat(1, "rst_after_msb", 0, 0, 0, 1);

    // Test 2: LSB scan of 9'b1_0010_0101 -> indices 0, 2, 5, 8.
    l_ivld = 1'b1; l_pry = 9'h125;
    settle();
    beat(0, "lsb_load", 0, 0, 0, 1);
    next_cycle(); l_ivld = 1'b0; settle();
    beat(0, "lsb_b1", 1, 0, 0, 0);
    next_cycle(); settle();
    beat(0, "lsb_b2", 1, 2, 0, 0);
    next_cycle(); settle();
    beat(0, "lsb_b3", 1, 5, 0, 0);
    // Test 3: next vector offered during the last beat is taken with no bubble.
    next_cycle(); l_ivld = 1'b1; l_pry = 9'h002; settle();
    beat(0, "lsb_b4_last", 1, 8, 1, 1);
    next_cycle(); l_ivld = 1'b0; settle();
    beat(0, "b2b_b1", 1, 1, 1, 1);
    next_cycle(); settle();
    beat(0, "b2b_idle", 0, 0, 0, 1);

    // Test 4: zero vector produces no beat; then back-pressure holds the first beat.
    l_ivld = 1'b1; l_pry = 9'h000;
    next_cycle(); l_ivld = 1'b0; settle();
    beat(0, "zero_after", 0, 0, 0, 1);
    l_ivld = 1'b1; l_pry = 9'h018; l_ordy = 1'b0;
    next_cycle(); l_ivld = 1'b0; settle();
    beat(0, "bp_hold1", 1, 3, 0, 0);
    next_cycle(); settle();
    beat(0, "bp_hold2", 1, 3, 0, 0);
    next_cycle(); settle();
    beat(0, "bp_hold3", 1, 3, 0, 0);
    next_cycle(); l_ordy = 1'b1; settle();
    beat(0, "bp_b1", 1, 3, 0, 0);
    next_cycle(); settle();
    beat(0, "bp_b2_last", 1, 4, 1, 1);
    next_cycle(); settle();
    beat(0, "bp_idle", 0, 0, 0, 1);

    // Test 5: MSB-first scan of 9'b1_0010_0101 -> 8, 5, 2, 0; then 9'h1FF -> 8 down to 0.
    m_ivld = 1'b1; m_pry = 9'h125;
    next_cycle(); m_ivld = 1'b0; settle();
    beat(1, "msb_b1", 1, 8, 0, 0);
    next_cycle(); settle();
    beat(1, "msb_b2", 1, 5, 0, 0);
    next_cycle(); settle();
    beat(1, "msb_b3", 1, 2, 0, 0);
    next_cycle(); m_ivld = 1'b1; m_pry = 9'h1FF; settle();
    beat(1, "msb_b4_last", 1, 0, 1, 1);
    next_cycle(); m_ivld = 1'b0;
    for (int k = 8; k >= 0; k--) begin
      settle();
      beat(1, $sformatf("msb_full_b%0d", 8 - k), 1, k, (k == 0), (k == 0));
      next_cycle();
    end
    settle();
    beat(1, "msb_full_idle", 0, 0, 0, 1);

    // Test 6: reset after the second beat of 9'h1FF discards the remainder.
    l_ivld = 1'b1; l_pry = 9'h1FF;
    next_cycle(); l_ivld = 1'b0; settle();
    beat(0, "mid_b1", 1, 0, 0, 0);
    next_cycle(); settle();
    beat(0, "mid_b2", 1, 1, 0, 0);
    next_cycle(); rst = 1'b1; l_ordy = 1'b0;
    next_cycle(); rst = 1'b0; l_ordy = 1'b1; settle();
    beat(0, "mid_after_rst", 0, 0, 0, 1);
    l_ivld = 1'b1; l_pry = 9'h040;
    next_cycle(); l_ivld = 1'b0; settle();
    beat(0, "post_rst_b1", 1, 6, 1, 1);
    next_cycle(); settle();
    beat(0, "post_rst_idle", 0, 0, 0, 1);
    beat(1, "msb_untouched", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
